// File: rtl/way_sel_pkg.sv
// Shared definitions for the way-select controller.
// Contents: geometry constants, FSM state enum, lowest-set-bit helper.
package way_sel_pkg;

    localparam int unsigned WAYS   = 8;
    localparam int unsigned SETS   = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned PLRU_W = 7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StResolve = 2'd1,
        StDone    = 2'd2
    } state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [SEL_W-1:0] lowest_one(input logic [7:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree8.sv
// Combinational 8-way tree-PLRU helper.
// Ports:
//   bits_i   - current 7 PLRU node bits (node 0 root, node k children 2k+1/2k+2)
//   access_i - way being accessed
//   victim_o - way the tree currently points at
//   bits_o   - node bits after the path to access_i is turned away from it
// A node bit of 0 points to the lower-index half.
module plru_tree8
    import way_sel_pkg::*;
(
    input  logic [PLRU_W-1:0] bits_i,
    input  logic [SEL_W-1:0]  access_i,
    output logic [SEL_W-1:0]  victim_o,
    output logic [PLRU_W-1:0] bits_o
);

    logic       v2;
    logic       v1;
    logic       v0;
    logic [2:0] vic_node1;
    logic [2:0] vic_node2;
    logic [2:0] acc_node1;
    logic [2:0] acc_node2;

    // Follow the pointers from the root down to a leaf.
    always_comb begin
        v2        = bits_i[0];
        vic_node1 = 3'd1 + {2'b00, v2};
        v1        = bits_i[vic_node1];
        vic_node2 = 3'd3 + {1'b0, v2, v1};
        v0        = bits_i[vic_node2];
        victim_o  = {v2, v1, v0};
    end

    // Each node on the accessed path points at the sibling half.
    always_comb begin
        acc_node1         = 3'd1 + {2'b00, access_i[2]};
        acc_node2         = 3'd3 + {1'b0, access_i[2:1]};
        bits_o            = bits_i;
        bits_o[0]         = ~access_i[2];
        bits_o[acc_node1] = ~access_i[1];
        bits_o[acc_node2] = ~access_i[0];
    end

endmodule

// File: rtl/way_select_ctrl.sv
// Way-select controller: resolves a lookup into a way select for the 8:1 way
// multiplexor (hit way, else first invalid way, else PLRU victim) and keeps
// per-set tree-PLRU state.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in idle)
//   req_index           - set index
//   hit_vec, valid_vec  - per-way tag match / line valid
//   sel, sel_valid      - way select, one-cycle qualifier
//   hit, multi_hit      - hit result and multiple-hit flag
//   hit_count, miss_count - saturating statistics (WAY_SEL_STATS_EN only)
// Optional feature macro: WAY_SEL_STATS_EN.
module way_select_ctrl #(
    parameter int unsigned WAYS = way_sel_pkg::WAYS,
    parameter int unsigned SETS = way_sel_pkg::SETS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [way_sel_pkg::IDX_W-1:0] req_index,
    input  logic [WAYS-1:0]               hit_vec,
    input  logic [WAYS-1:0]               valid_vec,
    output logic [way_sel_pkg::SEL_W-1:0] sel,
    output logic                          sel_valid,
    output logic                          hit,
`ifdef WAY_SEL_STATS_EN
    output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count,
`endif
    output logic                          multi_hit
);
    import way_sel_pkg::*;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAYS-1:0]   hv_q, hv_d;
    logic [WAYS-1:0]   vv_q, vv_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              hit_q, hit_d;
    logic              multi_q, multi_d;

    logic [PLRU_W-1:0] plru_q [SETS];
    logic [PLRU_W-1:0] plru_cur;
    logic [PLRU_W-1:0] plru_row_d;
    logic              plru_we;
    logic [SEL_W-1:0]  victim;

    assign plru_cur = plru_q[idx_q];

    // The set's bits are stable across RESOLVE and DONE, so one tree serves both
    // the victim lookup (RESOLVE) and the update toward sel_q (DONE).
    plru_tree8 u_plru_tree8 (
        .bits_i   (plru_cur),
        .access_i (sel_q),
        .victim_o (victim),
        .bits_o   (plru_row_d)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hv_d      = hv_q;
        vv_d      = vv_q;
        sel_d     = sel_q;
        hit_d     = hit_q;
        multi_d   = multi_q;
        plru_we   = 1'b0;
        req_ready = (state_q == StIdle) && !reset;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    idx_d   = req_index;
                    hv_d    = hit_vec;
                    vv_d    = valid_vec;
                    state_d = StResolve;
                end
            end
            StResolve: begin
                hit_d   = |hv_q;
                multi_d = |(hv_q & (hv_q - 1'b1));
                if (|hv_q) begin
                    sel_d = lowest_one(hv_q);
                end else if (vv_q != 8'hFF) begin
                    // All-invalid sets fall out here as way 0.
                    sel_d = lowest_one(~vv_q);
                end else begin
                    sel_d = victim;
                end
                state_d = StDone;
            end
            StDone: begin
                plru_we = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hv_q    <= '0;
            vv_q    <= '0;
            sel_q   <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hv_q    <= hv_d;
            vv_q    <= vv_d;
            sel_q   <= sel_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SETS); s++) begin
                plru_q[s] <= '0;
            end
        end else if (plru_we) begin
            plru_q[idx_q] <= plru_row_d;
        end
    end

    // Gated by reset so a request abandoned in DONE never shows a pulse.
    assign sel_valid = (state_q == StDone) && !reset;
    assign sel       = sel_q;
    assign hit       = hit_q;
    assign multi_hit = multi_q;

`ifdef WAY_SEL_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == StDone) begin
            if (hit_q) begin
                if (hit_count_q != 16'hFFFF) begin
                    hit_count_d = hit_count_q + 16'd1;
                end
            end else begin
                if (miss_count_q != 16'hFFFF) begin
                    miss_count_d = miss_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_way_select_ctrl.sv
// Directed self-checking bench for way_select_ctrl.
module tb_way_select_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_index;
    logic [7:0] hit_vec;
    logic [7:0] valid_vec;
    logic [2:0] sel;
    logic       sel_valid;
    logic       hit;
    logic       multi_hit;
`ifdef WAY_SEL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    way_select_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
        .hit_vec   (hit_vec),
        .valid_vec (valid_vec),
        .sel       (sel),
        .sel_valid (sel_valid),
        .hit       (hit),
`ifdef WAY_SEL_STATS_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
`endif
        .multi_hit (multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge in IDLE and follow it through DONE and back.
    task automatic do_req(input string tag, input logic [3:0] idx, input logic [7:0] hv,
                          input logic [7:0] vv, input logic [2:0] esel, input logic ehit,
                          input logic emulti);
        req_valid = 1'b1;
        req_index = idx;
        hit_vec   = hv;
        valid_vec = vv;
        #1;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        // RESOLVE: scramble inputs; the captured request must be unaffected.
        req_valid = 1'b0;
        req_index = ~idx;
        hit_vec   = ~hv;
        valid_vec = ~vv;
        chk({tag, ".rs_valid"}, {31'd0, sel_valid}, 32'd0);
        chk({tag, ".rs_ready"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, ".dn_valid"}, {31'd0, sel_valid}, 32'd1);
        chk({tag, ".sel"}, {29'd0, sel}, {29'd0, esel});
        chk({tag, ".hit"}, {31'd0, hit}, {31'd0, ehit});
        chk({tag, ".multi"}, {31'd0, multi_hit}, {31'd0, emulti});
        @(negedge clk);
        chk({tag, ".id_valid"}, {31'd0, sel_valid}, 32'd0);
        chk({tag, ".hold_sel"}, {29'd0, sel}, {29'd0, esel});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [2:0] exp_vic [9];

    initial begin
        exp_vic = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
        reset     = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        hit_vec   = '0;
        valid_vec = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", {31'd0, req_ready}, 32'd0);
        chk("rst.sel_valid", {31'd0, sel_valid}, 32'd0);
        chk("rst.sel", {29'd0, sel}, 32'd0);
        chk("rst.hit", {31'd0, hit}, 32'd0);
        chk("rst.multi", {31'd0, multi_hit}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", {31'd0, req_ready}, 32'd1);

        do_req("allinv", 4'd3, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        do_req("hit5", 4'd1, 8'h20, 8'hFF, 3'd5, 1'b1, 1'b0);
        do_req("multi", 4'd2, 8'h48, 8'hFF, 3'd3, 1'b1, 1'b1);
        do_req("fill3", 4'd4, 8'h00, 8'hE7, 3'd3, 1'b0, 1'b0);

        // PLRU walk on a full set with no hits.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            do_req($sformatf("plru%0d", i), 4'd7, 8'h00, 8'hFF, exp_vic[i], 1'b0, 1'b0);
        end

        // Reset during RESOLVE abandons the request.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 4'd7;
        hit_vec   = 8'h00;
        valid_vec = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("abort.rs_valid", {31'd0, sel_valid}, 32'd0);
        chk("abort.rs_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("abort.dn_valid", {31'd0, sel_valid}, 32'd0);
        chk("abort.sel", {29'd0, sel}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort.ready_after", {31'd0, req_ready}, 32'd1);
        chk("abort.no_pulse", {31'd0, sel_valid}, 32'd0);
        // Untouched set 7 bits give victims 0 then 4.
        do_req("abort.v0", 4'd7, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0);
        do_req("abort.v1", 4'd7, 8'h00, 8'hFF, 3'd4, 1'b0, 1'b0);

`ifdef WAY_SEL_STATS_EN
        do_reset();
        @(negedge clk);
        chk("stats.rst_hit", {16'd0, hit_count}, 32'd0);
        chk("stats.rst_miss", {16'd0, miss_count}, 32'd0);
        do_req("st.h0", 4'd0, 8'h01, 8'hFF, 3'd0, 1'b1, 1'b0);
        do_req("st.m0", 4'd0, 8'h00, 8'hFE, 3'd0, 1'b0, 1'b0);
        do_req("st.h1", 4'd0, 8'h80, 8'hFF, 3'd7, 1'b1, 1'b0);
        do_req("st.m1", 4'd0, 8'h00, 8'hFB, 3'd2, 1'b0, 1'b0);
        do_req("st.h2", 4'd0, 8'h06, 8'hFF, 3'd1, 1'b1, 1'b1);
        chk("stats.hit3", {16'd0, hit_count}, 32'd3);
        chk("stats.miss2", {16'd0, miss_count}, 32'd2);
        dut.hit_count_q = 16'hFFFE;
        do_req("st.s0", 4'd0, 8'h01, 8'hFF, 3'd0, 1'b1, 1'b0);
        chk("stats.sat1", {16'd0, hit_count}, 32'h0000FFFF);
        do_req("st.s1", 4'd0, 8'h01, 8'hFF, 3'd0, 1'b1, 1'b0);
        chk("stats.sat2", {16'd0, hit_count}, 32'h0000FFFF);
        chk("stats.miss_hold", {16'd0, miss_count}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/way_select_ctrl.md
WAY_SELECT_CTRL -- requirements
Module: way_select_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 8, number of ways; fixed at 8 in this revision.
REQ-002 SHALL have parameter SETS, default 16, number of sets tracked for replacement.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, lookup request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_index, input, 4, set index.
REQ-008 SHALL have port hit_vec, input, 8, per-way tag match.
REQ-009 SHALL have port valid_vec, input, 8, per-way line valid.
REQ-010 SHALL have port sel, output, 3, way select driven to the 8:1 way multiplexor.
REQ-011 SHALL have port sel_valid, output, 1, one-cycle pulse qualifying sel.
REQ-012 SHALL have port hit, output, 1, result was a hit (qualified by sel_valid).
REQ-013 SHALL have port multi_hit, output, 1, more than one hit_vec bit set (qualified by sel_valid).

Function
REQ-014 SHALL implement FSM IDLE -> RESOLVE -> DONE -> IDLE, one cycle per state.
REQ-015 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready.
REQ-016 SHALL register req_index, hit_vec and valid_vec at handshake; later input changes have no effect on that request.
REQ-017 SHALL, in RESOLVE, choose: lowest-index hit way if hit_vec!=0; else lowest-index invalid way if valid_vec!=8'hFF; else the PLRU victim of the set.
REQ-018 SHALL register the result so sel, hit and multi_hit are valid and sel_valid=1 for exactly the DONE cycle: handshake at cycle N -> sel_valid at N+2.
REQ-019 SHALL hold sel, hit and multi_hit stable outside DONE at their last values.
REQ-020 SHALL keep 7 tree-PLRU bits per set; node 0 root, node k children 2k+1/2k+2; bit=0 points to lower-index half.
REQ-021 SHALL, in DONE, update the indexed set's PLRU so every node on the path to sel points away from sel (hit or fill alike).
REQ-022 SHALL accept no new request in RESOLVE or DONE; maximum throughput one request per 3 cycles.
REQ-023 SHALL treat an all-invalid set as a miss selecting way 0.

Reset
REQ-024 SHALL, on reset, force IDLE, sel=0, sel_valid=0, hit=0, multi_hit=0 and all PLRU bits to 0.
REQ-025 SHALL, on reset asserted in RESOLVE or DONE, abandon the request with no sel_valid pulse and no PLRU update.
REQ-026 SHALL drive req_ready=0 while reset is high and 1 in the first cycle after deassertion.

Configuration
REQ-027 SHALL, with WAY_SEL_STATS_EN defined, add outputs hit_count[15:0] and miss_count[15:0], saturating at 16'hFFFF, incremented in DONE, cleared by reset.
REQ-028 SHALL, without WAY_SEL_STATS_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-029 SHALL place WAYS, SETS, IDX_W=4, SEL_W=3, PLRU_W=7 and the FSM state enum in shared package way_sel_pkg.
REQ-030 SHALL implement victim lookup and PLRU update as sub-module plru_tree8 (combinational: bits in, access way in -> victim out, next bits out).

Verification
REQ-031 SHALL cover: reset, then index 3, hit_vec=8'h00, valid_vec=8'h00 -> sel=0, hit=0, sel_valid exactly 2 cycles after handshake.
REQ-032 SHALL cover: hit_vec=8'h20, valid_vec=8'hFF -> sel=5, hit=1, multi_hit=0.
REQ-033 SHALL cover: hit_vec=8'h48 -> sel=3, hit=1, multi_hit=1.
REQ-034 SHALL cover: set 7 full with no hits, 8 back-to-back misses after reset -> victims 0,4,2,6,1,5,3,7.
REQ-035 SHALL cover: reset asserted in RESOLVE -> no sel_valid, set 7 PLRU bits unchanged, req_ready=1 the cycle after reset deasserts.
REQ-036 SHALL cover (WAY_SEL_STATS_EN): 3 hits and 2 misses -> hit_count=3, miss_count=2; counter preloaded near 16'hFFFF holds at 16'hFFFF.
